// File: rtl/mc_sequencer_pkg.sv
// Shared encodings for the multi-cycle sequencer: states, next-PC/GPR/WD selects,
// exception causes, opcode constants and the opcode-class decoder.
package mc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_EXCPT  = 3'd6
  } state_e;

  localparam logic [2:0] NPC_PLUS4  = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;
  localparam logic [2:0] NPC_EXCEPT = 3'd4;

  localparam logic [1:0] GPRSel_RD = 2'd0;
  localparam logic [1:0] GPRSel_RT = 2'd1;
  localparam logic [1:0] GPRSel_31 = 2'd2;

  localparam logic [2:0] WDSel_FromALU = 3'd0;
  localparam logic [2:0] WDSel_FromMEM = 3'd1;
  localparam logic [2:0] WDSel_FromPC  = 3'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_BUS     = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [3:0] {
    CLS_R, CLS_JR, CLS_I, CLS_LW, CLS_SW,
    CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_ILL
  } opclass_e;

  function automatic opclass_e classify(input logic [5:0] op, input logic [5:0] fn);
    opclass_e cls;
    cls = CLS_ILL;
    if (op == OP_RTYPE) begin
      cls = (fn == FN_JR) ? CLS_JR : CLS_R;
    end else if (op[5:3] == 3'b001) begin
      cls = CLS_I;
    end else begin
      case (op)
        OP_LW:   cls = CLS_LW;
        OP_SW:   cls = CLS_SW;
        OP_BEQ:  cls = CLS_BEQ;
        OP_BNE:  cls = CLS_BNE;
        OP_J:    cls = CLS_J;
        OP_JAL:  cls = CLS_JAL;
        default: cls = CLS_ILL;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/mc_sequencer_timeout.sv
// Memory wait counter: counts unacknowledged request cycles and flags expiry
// on the last permitted cycle unless the ack arrives in that same cycle.
module mc_timeout #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_expired
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] r_wait_cnt;

  assign o_expired = i_busy && !i_ack && (r_wait_cnt == LIMIT);

  // Expiry leaves FETCH/MEM, so the counter clears rather than advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (i_busy && !i_ack && !o_expired) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and raises exceptions for illegal opcodes and bus timeouts.
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [2:0]       pc_src,
  output logic             rf_wr,
  output logic [1:0]       gpr_sel,
  output logic [2:0]       wd_sel,
  output logic [2:0]       state,
  output logic             exc,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] retired
);

  state_e     r_state;
  state_e     w_next;
  opclass_e   w_cls;
  logic       w_expired;
  logic       w_retire;
  logic       w_cause_ld;
  logic [1:0] w_cause;
  logic [1:0] r_cause;
  logic [CNT_W-1:0] r_retired;

  assign w_cls     = classify(opcode, funct);
  assign state     = r_state;
  assign exc_cause = r_cause;
  assign retired   = r_retired;

  mc_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_busy   (mem_req),
    .i_ack    (mem_ack),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_BOOT;
      r_cause   <= CAUSE_NONE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_cause_ld) r_cause <= w_cause;
      if (w_retire)   r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    w_cause_ld = 1'b0;
    w_cause    = CAUSE_NONE;
    case (r_state)
      ST_BOOT: w_next = ST_FETCH;
      ST_FETCH: begin
        if (mem_ack) begin
          w_next = ST_DECODE;
        end else if (w_expired) begin
          w_next = ST_EXCPT; w_cause_ld = 1'b1; w_cause = CAUSE_BUS;
        end
      end
      ST_DECODE: begin
        case (w_cls)
          CLS_ILL: begin
            w_next = ST_EXCPT; w_cause_ld = 1'b1; w_cause = CAUSE_ILLEGAL;
          end
          CLS_J, CLS_JAL: begin w_next = ST_FETCH; w_retire = 1'b1; end
          default: w_next = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (w_cls)
          CLS_R, CLS_I:              w_next = ST_WB;
          CLS_LW, CLS_SW:            w_next = ST_MEM;
          CLS_JR, CLS_BEQ, CLS_BNE:  begin w_next = ST_FETCH; w_retire = 1'b1; end
          default:                   w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (w_cls == CLS_SW) begin
            w_next = ST_FETCH; w_retire = 1'b1;
          end else begin
            w_next = ST_WB;
          end
        end else if (w_expired) begin
          w_next = ST_EXCPT; w_cause_ld = 1'b1; w_cause = CAUSE_BUS;
        end
      end
      ST_WB:    begin w_next = ST_FETCH; w_retire = 1'b1; end
      ST_EXCPT: w_next = ST_FETCH;
      default:  w_next = ST_BOOT;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_wr        = 1'b0;
    pc_wr        = 1'b0;
    pc_src       = NPC_PLUS4;
    rf_wr        = 1'b0;
    gpr_sel      = GPRSel_RD;
    wd_sel       = WDSel_FromALU;
    exc          = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_wr = 1'b1; pc_wr = 1'b1; pc_src = NPC_PLUS4;
        end
      end
      ST_DECODE: begin
        if (w_cls == CLS_J || w_cls == CLS_JAL) begin
          pc_wr = 1'b1; pc_src = NPC_JUMP;
        end
        if (w_cls == CLS_JAL) begin
          rf_wr = 1'b1; gpr_sel = GPRSel_31; wd_sel = WDSel_FromPC;
        end
      end
      ST_EXEC: begin
        case (w_cls)
          CLS_JR:  begin pc_wr = 1'b1; pc_src = NPC_JR; end
          CLS_BEQ: begin pc_wr = zero;  pc_src = NPC_BRANCH; end
          CLS_BNE: begin pc_wr = !zero; pc_src = NPC_BRANCH; end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1; mem_addr_sel = 1'b1; mem_we = (w_cls == CLS_SW);
      end
      ST_WB: begin
        rf_wr   = 1'b1;
        gpr_sel = (w_cls == CLS_R)  ? GPRSel_RD     : GPRSel_RT;
        wd_sel  = (w_cls == CLS_LW) ? WDSel_FromMEM : WDSel_FromALU;
      end
      ST_EXCPT: begin
        pc_wr = 1'b1; pc_src = NPC_EXCEPT; exc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: builds the expected per-cycle output trace of each
// instruction from its class and memory wait counts, then steps the DUT against it.
module tb_mc_sequencer;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ack;
  logic       mem_req, mem_we, mem_addr_sel, ir_wr, pc_wr, rf_wr, exc;
  logic [2:0] pc_src, wd_sel, state;
  logic [1:0] gpr_sel, exc_cause;
  logic [3:0] retired;

  mc_sequencer #(.MEM_TIMEOUT(T), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .rf_wr(rf_wr), .gpr_sel(gpr_sel),
    .wd_sel(wd_sel), .state(state), .exc(exc), .exc_cause(exc_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] v;
    logic        ack;
  } cyc_t;

  cyc_t       q[$];
  int         checks = 0;
  int         failures = 0;
  int         m_retired = 0;
  int         m_cause = 0;
  bit         noise = 0;
  logic [5:0] cur_op, cur_fn;
  logic       cur_z;

  function automatic logic [23:0] observed();
    return {state, mem_req, mem_we, mem_addr_sel, ir_wr, pc_wr, pc_src, rf_wr,
            gpr_sel, wd_sel, exc, exc_cause, retired};
  endfunction

  task automatic push(input int st, input bit req, input bit we, input bit asel,
                      input bit irw, input bit pcw, input int pcs, input bit rfw,
                      input int gs, input int ws, input bit ex, input bit ack);
    cyc_t c;
    c.v = {st[2:0], req, we, asel, irw, pcw, pcs[2:0], rfw, gs[1:0], ws[2:0], ex,
           m_cause[1:0], m_retired[3:0]};
    c.ack = ack;
    q.push_back(c);
  endtask

  function automatic bit rnd_ack();
    return noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic push_plain(input int st);
    push(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rnd_ack());
  endtask

  task automatic push_excpt();
    push(6, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, rnd_ack());
  endtask

  // Request cycles without ack; too many waits ends in a bus-timeout exception.
  task automatic mem_wait(input int st, input bit asel, input bit we, input int waits,
                          output bit ok);
    int n;
    n = (waits >= T) ? T : waits;
    for (int i = 0; i < n; i++) push(st, 1, we, asel, 0, 0, 0, 0, 0, 0, 0, 0);
    ok = (waits < T);
    if (!ok) begin
      m_cause = 2;
      push_excpt();
    end
  endtask

  task automatic plan_instr(input int op, input int fn, input bit z, input int fw, input int mw);
    bit ok, ret, is_r, is_jr, is_i, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    ret    = 0;
    is_r   = (op == 0) && (fn != 8);
    is_jr  = (op == 0) && (fn == 8);
    is_i   = (op >= 8) && (op <= 15);
    is_lw  = (op == 35);
    is_sw  = (op == 43);
    is_beq = (op == 4);
    is_bne = (op == 5);
    is_j   = (op == 2);
    is_jal = (op == 3);
    mem_wait(1, 0, 0, fw, ok);
    if (!ok) return;
    push(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    if (!(is_r || is_jr || is_i || is_lw || is_sw || is_beq || is_bne || is_j || is_jal)) begin
      push_plain(2);
      m_cause = 1;
      push_excpt();
      return;
    end
    if (is_j) begin
      push(2, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, rnd_ack()); ret = 1;
    end else if (is_jal) begin
      push(2, 0, 0, 0, 0, 1, 2, 1, 2, 2, 0, rnd_ack()); ret = 1;
    end else begin
      push_plain(2);
      if (is_r || is_i) begin
        push_plain(3);
        push(5, 0, 0, 0, 0, 0, 0, 1, is_r ? 0 : 1, 0, 0, rnd_ack()); ret = 1;
      end else if (is_jr) begin
        push(3, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, rnd_ack()); ret = 1;
      end else if (is_beq || is_bne) begin
        push(3, 0, 0, 0, 0, is_beq ? z : !z, 1, 0, 0, 0, 0, rnd_ack()); ret = 1;
      end else begin
        push_plain(3);
        mem_wait(4, 1, is_sw, mw, ok);
        if (!ok) return;
        push(4, 1, is_sw, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        if (is_lw) push(5, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, rnd_ack());
        ret = 1;
      end
    end
    if (ret) m_retired = m_retired + 1;
  endtask

  task automatic run_plan(input string name, input int max_cyc);
    cyc_t c;
    logic [23:0] got;
    int n;
    n = 0;
    while (q.size() > 0 && n < max_cyc) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      opcode  = cur_op;
      funct   = cur_fn;
      zero    = cur_z;
      mem_ack = c.ack;
      #1;
      got = observed();
      checks++;
      if (got !== c.v) begin
        failures++;
        $display("FAIL %s cyc%0d: got st=%0d req/we/as/ir/pc=%b pcs=%0d rf=%b gs=%0d ws=%0d exc=%b cause=%0d ret=%0d ; exp st=%0d req/we/as/ir/pc=%b pcs=%0d rf=%b gs=%0d ws=%0d exc=%b cause=%0d ret=%0d",
                 name, n, got[23:21], got[20:16], got[15:13], got[12], got[11:10], got[9:7],
                 got[6], got[5:4], got[3:0], c.v[23:21], c.v[20:16], c.v[15:13], c.v[12],
                 c.v[11:10], c.v[9:7], c.v[6], c.v[5:4], c.v[3:0]);
      end
      n++;
    end
  endtask

  task automatic do_instr(input string name, input int op, input int fn, input bit z,
                          input int fw, input int mw);
    cur_op = 6'(op);
    cur_fn = 6'(fn);
    cur_z  = z;
    plan_instr(op, fn, z, fw, mw);
    run_plan(name, 1000);
  endtask

  task automatic release_reset(input string name);
    @(negedge clk);
    rst_n = 1'b1;
    m_retired = 0;
    m_cause = 0;
    #1;
    checks++;
    if (observed() !== 24'h0) begin
      failures++;
      $display("FAIL %s_boot: got %h required %h", name, observed(), 24'h0);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    zero    = 1'b1;
    opcode  = 6'h23;
    funct   = 6'h08;
    #3;
    checks++;
    if (observed() !== 24'h0) begin
      failures++;
      $display("FAIL reset_state: got %h required %h", observed(), 24'h0);
    end
    repeat (2) @(posedge clk);
    release_reset("reset");
  endtask

  task automatic test_addu();
    noise = 0;
    do_instr("addu", 0, 8'h21, 0, 0, 0);
  endtask

  task automatic test_lw();
    do_instr("lw_waits", 8'h23, 0, 0, 3, 2);
  endtask

  task automatic test_bne();
    do_instr("bne_z1", 5, 0, 1, 0, 0);
    do_instr("bne_z0", 5, 0, 0, 0, 0);
    do_instr("beq_z1", 4, 0, 1, 1, 0);
  endtask

  task automatic test_jumps();
    do_instr("j", 2, 0, 0, 0, 0);
    do_instr("jal", 3, 0, 0, 2, 0);
    do_instr("jr", 0, 8, 0, 0, 0);
    do_instr("sw", 8'h2B, 0, 0, 0, 1);
    do_instr("ori", 8'h0D, 0, 0, 0, 0);
  endtask

  task automatic test_illegal();
    do_instr("illegal", 8'h3F, 0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    do_instr("tmo_fetch", 0, 8'h21, 0, T, 0);
    do_instr("ack_last", 0, 8'h21, 0, T - 1, 0);
    do_instr("tmo_mem", 8'h23, 0, 0, 0, T);
    do_instr("mem_ack_last", 8'h2B, 0, 0, 0, T - 1);
  endtask

  task automatic test_random();
    int op, fn, fw, mw;
    bit z;
    noise = 1;
    for (int i = 0; i < 60; i++) begin
      fn = int'($urandom_range(0, 63));
      case ($urandom_range(0, 9))
        0:       begin op = 0; if ($urandom_range(0, 3) == 0) fn = 8; end
        1:       op = int'($urandom_range(8, 15));
        2:       op = 8'h23;
        3:       op = 8'h2B;
        4:       op = 4;
        5:       op = 5;
        6:       op = 2;
        7:       op = 3;
        default: op = int'($urandom_range(0, 63));
      endcase
      fw = int'($urandom_range(0, T));
      if (fw == T && $urandom_range(0, 2) != 0) fw = int'($urandom_range(0, T - 1));
      mw = int'($urandom_range(0, T));
      if (mw == T && $urandom_range(0, 2) != 0) mw = int'($urandom_range(0, T - 1));
      z = 1'($urandom_range(0, 1));
      do_instr("random", op, fn, z, fw, mw);
    end
    noise = 0;
  endtask

  task automatic test_reset_mid_mem();
    cur_op = 6'h2B;
    cur_fn = 6'h00;
    cur_z  = 1'b0;
    plan_instr(8'h2B, 0, 0, 0, 2);
    run_plan("sw_pre_rst", 4);
    q.delete();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, state, retired} !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_mem: got req=%b st=%0d ret=%0d required req=0 st=0 ret=0",
               mem_req, state, retired);
    end
    release_reset("rst_mid_mem");
    do_instr("after_rst", 0, 8'h21, 0, 0, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    opcode  = '0;
    funct   = '0;
    zero    = 1'b0;
    mem_ack = 1'b0;
    cur_op  = '0;
    cur_fn  = '0;
    cur_z   = 1'b0;
    test_reset();
    test_addu();
    test_lw();
    test_bne();
    test_jumps();
    test_illegal();
    test_timeout();
    test_random();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle control sequencer for the MIPS core. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
- Issues per-cycle write strobes (PC, IR, GPR) and owns the memory request handshake with timeout.
- Raises the exception redirect for illegal opcodes and bus timeouts.
- The existing combinational decoder still supplies ALUOp/ASel/BSel/EXTOp; this block only decides *when* things happen.

Parameters:
- MEM_TIMEOUT, 16, cycles mem_req may stay unacknowledged before a bus-error exception; legal range 2..255.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  store request, qualified by mem_req
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_wr  out  1  latch fetched word into IR
- pc_wr  out  1  PC update strobe
- pc_src  out  3  NPC_PLUS4 / NPC_BRANCH / NPC_JUMP / NPC_JR / NPC_EXCEPT
- rf_wr  out  1  GPR write strobe
- gpr_sel  out  2  GPRSel_RD / GPRSel_RT / GPRSel_31
- wd_sel  out  3  WDSel_FromALU / WDSel_FromMEM / WDSel_FromPC
- state  out  3  current state, for debug
- exc  out  1  one-cycle exception pulse
- exc_cause  out  2  0 none, 1 illegal, 2 bus timeout; held until the next exception
- retired  out  CNT_W  count of completed instructions

Behaviour:
- **Reset:** rst_n low asynchronously forces state=BOOT, wait_cnt=0, retired=0, exc_cause=0. All strobes (mem_req, mem_we, ir_wr, pc_wr, rf_wr, exc) are 0 in BOOT. Select outputs are 0 whenever not otherwise specified.
- **State encodings:** BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, EXCPT=6. Unused encodings go to BOOT.
- **Opcode classes:**
  - R = 0x00; JR = R with funct 0x08.
  - I = 0x08..0x0F; LW = 0x23; SW = 0x2B.
  - BEQ = 0x04; BNE = 0x05; J = 0x02; JAL = 0x03.
  - Anything else is illegal.
- **BOOT:** one cycle, then FETCH.
- **FETCH:** mem_req=1, mem_addr_sel=0, mem_we=0.
  - On mem_ack: ir_wr=1, pc_wr=1, pc_src=PLUS4, go to DECODE.
- **DECODE:**
  - Illegal: go to EXCPT with cause 1.
  - J: pc_wr=1, pc_src=JUMP, go to FETCH, retire.
  - JAL: additionally rf_wr=1, gpr_sel=31, wd_sel=PC.
  - All other classes: go to EXEC.
- **EXEC:**
  - R (not JR) or I: go to WB.
  - JR: pc_wr=1, pc_src=JR, go to FETCH, retire.
  - LW/SW: go to MEM.
  - BEQ/BNE: pc_src=BRANCH; pc_wr=(BEQ&zero)|(BNE&~zero); go to FETCH, retire (taken or not).
- **MEM:** mem_req=1, mem_addr_sel=1, mem_we=SW.
  - On mem_ack: SW goes to FETCH and retires; LW goes to WB.
- **WB:** rf_wr=1, then FETCH and retire.
  - gpr_sel = RD for R, RT otherwise.
  - wd_sel = MEM for LW, ALU otherwise.
- **EXCPT:** pc_wr=1, pc_src=EXCEPT, exc=1 for one cycle, then FETCH. An exception does not increment retired.
- **Timeout counter (wait_cnt):**
  - Increments each cycle mem_req=1 and mem_ack=0; clears on ack or on leaving FETCH/MEM.
  - When wait_cnt = MEM_TIMEOUT-1 and mem_ack=0: go to EXCPT with cause 2; no strobe is issued.
  - If mem_ack arrives in that same cycle, the ack wins.
- **mem_ack outside FETCH/MEM:** ignored.
- **retired:** +1 on each retire event; wraps modulo 2^CNT_W.
- **Output timing:** strobes and selects are combinational from state and inputs (Mealy on mem_ack and zero). state, wait_cnt, exc_cause and retired are registered. Reset mid-request drops mem_req immediately.

Decomposition:
- ctrl_encode_def.v gains:
  - state encodings;
  - GPRSel_31 and WDSel_FromMEM;
  - exception cause codes.
- The existing NPC_* codes are reused unchanged.
- instruction_def.v supplies the opcode/funct constants, adding LW/SW/BNE if absent.
- One natural sub-module: mc_timeout (wait counter plus expiry compare).

Test Plan:
- **ADDU (op 0x00, funct 0x21), ack on first request cycle:** FETCH→DECODE→EXEC→WB→FETCH. rf_wr=1 with gpr_sel=RD in WB only; retired 0→1.
- **LW with FETCH ack after 3 waits and MEM ack after 2:** mem_addr_sel 0 then 1; rf_wr in WB with wd_sel=MEM; total 10 cycles; retired +1.
- **BNE with zero=1, then BNE with zero=0:** first has pc_wr=0 in EXEC; second has pc_wr=1 with pc_src=NPC_BRANCH. Both retire.
- **Illegal opcode 0x3F:** DECODE→EXCPT; exc pulse of 1 cycle; exc_cause=1; pc_src=NPC_EXCEPT; retired unchanged.
- **MEM_TIMEOUT=4, mem_ack never asserted in FETCH:** EXCPT entered 4 cycles after FETCH entry; exc_cause=2. Repeat with ack on exactly the 4th cycle: normal DECODE, no exception.
- **rst_n pulsed low mid-MEM of SW:** mem_req drops same cycle. After release: BOOT, then FETCH; retired=0.
